// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle MIPS core.
// Sequences the shared memory port, ALU, register file, IR and PC, one
// state per cycle, and decodes the current state (plus the opcode in
// Decode/MemAddr) into mux selects, ALU op and write strobes.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   opcode          IR[31:26]
//   alu_zero        ALU zero flag (used in Beq)
//   mem_ready       memory completes the current access this cycle
//   state           current FSM state (debug)
//   mem_addr_sel, alu_srca_sel, alu_srcb_sel, alu_op, wreg_dst_sel,
//   wrbck_data_sel, nxt_pc_sel   datapath selects
//   ir_wr, mem_rd, mem_wr, reg_wr, pc_en   write/access strobes
//   instr_done      last cycle of an instruction
//   illegal_op      unsupported opcode seen in Decode
//
// Build option: define MULTCYC_ADDIU_EN to compile in the ADDIU path
// (AddiuExec state, encoding 12). Without it ADDIU is an illegal opcode.
//
// Outputs follow the state combinationally (they must reflect the current
// state and the same-cycle mem_ready/alu_zero) and are forced low while
// rst_n is asserted, so a reset aborts any access immediately.

module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic       mem_addr_sel,
    output logic       alu_srca_sel,
    output logic [1:0] alu_srcb_sel,
    output logic [1:0] alu_op,
    output logic       wreg_dst_sel,
    output logic       wrbck_data_sel,
    output logic [1:0] nxt_pc_sel,
    output logic       ir_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op
);

    localparam int unsigned ST_W  = 4;
    localparam int unsigned OPC_W = 6;

    // Opcode encodings (IR[31:26])
    localparam logic [OPC_W-1:0] OP_RR    = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
`ifdef MULTCYC_ADDIU_EN
    localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
`endif
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    // ALU operations
    localparam logic [1:0] ALUOP_ADD  = 2'd0;
    localparam logic [1:0] ALUOP_SUB  = 2'd1;
    localparam logic [1:0] ALUOP_RR   = 2'd2;
    localparam logic [1:0] ALUOP_ADDU = 2'd3;

    // Datapath select encodings
    localparam logic       ADDR_ALUOUT = 1'b1;
    localparam logic       SRCA_RS     = 1'b1;
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_BEQIMM = 2'd3;
    localparam logic       WR_RT       = 1'b0;
    localparam logic       WR_RD       = 1'b1;
    localparam logic       WB_ALUOUT   = 1'b0;
    localparam logic       WB_MEMDATA  = 1'b1;
    localparam logic [1:0] PC_BRANCH   = 2'd1;
    localparam logic [1:0] PC_JMP      = 2'd2;

    typedef enum logic [ST_W-1:0] {
        S_FETCH       = 4'd0,
        S_DECODE      = 4'd1,
        S_MEM_ADDR    = 4'd2,
        S_MEM_RD      = 4'd3,
        S_MEM_WRBCK   = 4'd4,
        S_MEM_WR      = 4'd5,
        S_RR_EXEC     = 4'd6,
        S_ALU_RR_WRBCK = 4'd7,
        S_BEQ         = 4'd8,
        S_JMP         = 4'd9,
        S_ADDI_EXEC   = 4'd10,
        S_ALU_RI_WRBCK = 4'd11,
        S_ADDIU_EXEC  = 4'd12
    } state_t;

    state_t cur_state, nxt_state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    assign state = cur_state;

    // Next-state and output decode
    always_comb begin
        nxt_state      = S_FETCH;
        mem_addr_sel   = 1'b0;
        alu_srca_sel   = 1'b0;
        alu_srcb_sel   = SRCB_RT;
        alu_op         = ALUOP_ADD;
        wreg_dst_sel   = WR_RT;
        wrbck_data_sel = WB_ALUOUT;
        nxt_pc_sel     = 2'd0;
        ir_wr          = 1'b0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        reg_wr         = 1'b0;
        pc_en          = 1'b0;
        instr_done     = 1'b0;
        illegal_op     = 1'b0;

        if (rst_n) begin
            unique case (cur_state)
                S_FETCH: begin
                    mem_rd       = 1'b1;
                    alu_srcb_sel = SRCB_FOUR;
                    ir_wr        = mem_ready;
                    pc_en        = mem_ready;
                    nxt_state    = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    // Precompute the branch target into ALUout
                    alu_srcb_sel = SRCB_BEQIMM;
                    alu_op       = ALUOP_ADD;
                    unique case (opcode)
                        OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
                        OP_RR:        nxt_state = S_RR_EXEC;
                        OP_BEQ:       nxt_state = S_BEQ;
                        OP_J:         nxt_state = S_JMP;
                        OP_ADDI:      nxt_state = S_ADDI_EXEC;
`ifdef MULTCYC_ADDIU_EN
                        OP_ADDIU:     nxt_state = S_ADDIU_EXEC;
`endif
                        default: begin
                            nxt_state  = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_srca_sel = SRCA_RS;
                    alu_srcb_sel = SRCB_IMM;
                    alu_op       = ALUOP_ADD;
                    nxt_state    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    mem_addr_sel = ADDR_ALUOUT;
                    mem_rd       = 1'b1;
                    nxt_state    = mem_ready ? S_MEM_WRBCK : S_MEM_RD;
                end
                S_MEM_WRBCK: begin
                    reg_wr         = 1'b1;
                    wreg_dst_sel   = WR_RT;
                    wrbck_data_sel = WB_MEMDATA;
                    instr_done     = 1'b1;
                    nxt_state      = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_addr_sel = ADDR_ALUOUT;
                    mem_wr       = 1'b1;
                    instr_done   = mem_ready;
                    nxt_state    = mem_ready ? S_FETCH : S_MEM_WR;
                end
                S_RR_EXEC: begin
                    alu_srca_sel = SRCA_RS;
                    alu_srcb_sel = SRCB_RT;
                    alu_op       = ALUOP_RR;
                    nxt_state    = S_ALU_RR_WRBCK;
                end
                S_ALU_RR_WRBCK: begin
                    reg_wr         = 1'b1;
                    wreg_dst_sel   = WR_RD;
                    wrbck_data_sel = WB_ALUOUT;
                    instr_done     = 1'b1;
                    nxt_state      = S_FETCH;
                end
                S_BEQ: begin
                    alu_srca_sel = SRCA_RS;
                    alu_srcb_sel = SRCB_RT;
                    alu_op       = ALUOP_SUB;
                    nxt_pc_sel   = PC_BRANCH;
                    pc_en        = alu_zero;
                    instr_done   = 1'b1;
                    nxt_state    = S_FETCH;
                end
                S_JMP: begin
                    nxt_pc_sel = PC_JMP;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                    nxt_state  = S_FETCH;
                end
                S_ADDI_EXEC: begin
                    alu_srca_sel = SRCA_RS;
                    alu_srcb_sel = SRCB_IMM;
                    alu_op       = ALUOP_ADD;
                    nxt_state    = S_ALU_RI_WRBCK;
                end
`ifdef MULTCYC_ADDIU_EN
                S_ADDIU_EXEC: begin
                    alu_srca_sel = SRCA_RS;
                    alu_srcb_sel = SRCB_IMM;
                    alu_op       = ALUOP_ADDU;
                    nxt_state    = S_ALU_RI_WRBCK;
                end
`endif
                S_ALU_RI_WRBCK: begin
                    reg_wr         = 1'b1;
                    wreg_dst_sel   = WR_RT;
                    wrbck_data_sel = WB_ALUOUT;
                    instr_done     = 1'b1;
                    nxt_state      = S_FETCH;
                end
                // Unused encodings recover to Fetch with all strobes low
                default: nxt_state = S_FETCH;
            endcase
        end
    end

endmodule
